key_conditioner: RTL

- Parametrised front end that turns raw, bouncy, asynchronous key inputs into clean per-key events for `core` and its successors.
- Each channel is synchronised, debounced, edge-detected and optionally auto-repeated while held.
- Also provides a priority-encoded code for the current cycle's press/repeat event.
- Sits between the board key pins and the `keystroke` consumers; clocked by the raw board clock.

---
 rtl/key_pkg.sv | 33 +++
 rtl/key_channel.sv | 70 +++++++
 rtl/key_conditioner.sv | 57 +++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared defaults, key indices and helpers for the key front end.
package key_pkg;

  localparam int NUM_KEYS_DEF     = 12;
  localparam int DEBOUNCE_DEF     = 200000;
  localparam int REPEAT_DELAY_DEF = 25000000;
  localparam int REPEAT_RATE_DEF  = 5000000;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_SEL   = 4;
  localparam int KEY_BACK  = 5;
  localparam int KEY_MENU  = 6;
  localparam int KEY_PLAY  = 7;
  localparam int KEY_F1    = 8;
  localparam int KEY_F2    = 9;
  localparam int KEY_F3    = 10;
  localparam int KEY_F4    = 11;

  typedef struct packed {
    logic lvl;
    logic prs;
    logic rls;
    logic rpt;
  } key_evt_t;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop sync, debounce, edge detect and auto-repeat.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter int CNT_W           = cnt_width(DEBOUNCE_DEF, REPEAT_DELAY_DEF)
) (
  input  logic     clk_raw,
  input  logic     rst_n,
  input  logic     raw,
  input  logic     rpt_en,
  output key_evt_t evt
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_TOP  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(REPEAT_DELAY - REPEAT_RATE);

  logic             s1;
  logic             s2;
  logic             stable;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt;
  logic             fire;

  assign fire = level & rpt_en & (rcnt == RD_TOP);

  always_ff @(posedge clk_raw) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      stable  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      dcnt    <= '0;
      rcnt    <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level   <= stable;
      level_q <= level;
      if (s2 == stable) begin
        dcnt <= '0;
      end else if (dcnt == DB_LAST) begin
        stable <= s2;
        dcnt   <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      // rcnt counts held cycles; a fire reloads and counts this cycle too
      if (!(level && rpt_en)) begin
        rcnt <= '0;
      end else if (fire) begin
        rcnt <= RELOAD + 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end

  assign evt.lvl = level;
  assign evt.prs = level & ~level_q;
  assign evt.rls = ~level & level_q;
  assign evt.rpt = fire;

endmodule

// File: rtl/key_conditioner.sv
// Key front end: per-key channels plus lowest-index event encoder.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF
) (
  input  logic                        clk_raw,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         keystroke,
  input  logic [NUM_KEYS-1:0]         rpt_en,
  output logic [NUM_KEYS-1:0]         key_level,
  output logic [NUM_KEYS-1:0]         key_press,
  output logic [NUM_KEYS-1:0]         key_release,
  output logic [NUM_KEYS-1:0]         key_repeat,
  output logic                        evt_valid,
  output logic [$clog2(NUM_KEYS)-1:0] evt_code
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY);
  localparam int CODE_W = $clog2(NUM_KEYS);

  key_evt_t            evts [NUM_KEYS];
  logic [NUM_KEYS-1:0] hits;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk_raw(clk_raw),
      .rst_n  (rst_n),
      .raw    (keystroke[g]),
      .rpt_en (rpt_en[g]),
      .evt    (evts[g])
    );
    assign key_level[g]   = evts[g].lvl;
    assign key_press[g]   = evts[g].prs;
    assign key_release[g] = evts[g].rls;
    assign key_repeat[g]  = evts[g].rpt;
  end

  assign hits      = key_press | key_repeat;
  assign evt_valid = |hits;

  always_comb begin
    evt_code = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (hits[i]) evt_code = CODE_W'(i);
    end
  end

endmodule
